bidir_line_arbiter: RTL and testbench
=====================================

# bidir_line_arbiter

Sequences and shares one bidirectional pad, driven through a `BB` primitive, between two requesters. Each transaction is a single-bit write (drive) or read (release and sample). The block round-robin arbitrates, inserts turnaround cycles on direction changes, holds or settles the line for programmed times, and returns a one-cycle acknowledge with read data. It sits between test or bring-up logic and the pad's `BB` instance, replacing hand-wired direction control.

## Interface
- `TURNAROUND`, 2: released cycles inserted before a write that follows a read (range 0..15).
- `HOLD`, 4: cycles the line is driven per write (range 1..255).
- `SETTLE`, 4: released cycles per read before sampling (range 3..255).
- `clock`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `req0`, `req1`  in  1  level request; held until the matching ack.
- `wr0`, `wr1`  in  1  1 = write, 0 = read; sampled at grant.
- `wdata0`, `wdata1`  in  1  write bit; sampled at grant.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  1  read result; valid from ack and held until the next read ack to that requester.
- `busy`  out  1  high in every state except IDLE.
- `owner`  out  1  requester granted for the current or last transaction.
- `bb_i`  out  1  to `BB.I`.
- `bb_t`  out  1  to `BB.T`; 1 = released (tristate).
- `bb_o`  in  1  from `BB.O`; asynchronous; passes through a 2-flop synchronizer.

## Operation
- States:
  - IDLE: arbitrate.
  - TURN: released, counting `TURNAROUND`.
  - DRIVE: `bb_t=0`, `bb_i=wdata`, counting `HOLD`.
  - SETTLE: released, counting `SETTLE`.
  - ACK: pulse the ack.
  - ACK always returns to IDLE.
- Arbitration happens only in IDLE.
  - One requester asserted: grant it.
  - Both asserted: grant the requester not served last.
  - After reset, req0 wins a tie.
  - Granted `wr`/`wdata` are captured in the grant cycle.
- `cur_dir` holds the direction of the last completed transaction; its reset value is read.
- Transitions out of IDLE:
  - Write with `cur_dir`=read and `TURNAROUND`>0 → TURN → DRIVE.
  - Write otherwise → DRIVE.
  - Read → SETTLE. No separate TURN for reads; SETTLE itself is released time.
- Read data is the synchronizer output captured at the edge ending the last SETTLE cycle.
- A request dropped before its ack is ignored: the transaction completes and the ack still fires.
- `req` still high in the IDLE cycle after an ack counts as a new request.
- Line in IDLE, ACK, TURN and SETTLE: `bb_t=1`, `bb_i=0` (exception under Configuration).
- Reset values: `bb_t=1`, `bb_i=0`, acks 0, rdata 0, `busy`=0, `owner`=0, state IDLE, round-robin pointer favours req0.
- Reset asserted mid-transaction:
  - Outputs take their reset values asynchronously, within the same cycle.
  - No ack is issued.
  - The transaction is discarded.

## Timing
- Cycle 0 is the IDLE cycle where the request is seen.
- Write, no turnaround: DRIVE in cycles 1..`HOLD`, ACK in cycle `HOLD`+1, IDLE in cycle `HOLD`+2.
- Write with turnaround: TURN in cycles 1..`TURNAROUND`, then the same sequence shifted by `TURNAROUND`.
- Read: SETTLE in cycles 1..`SETTLE`, ACK with rdata valid in cycle `SETTLE`+1.
- Sampled pad value is the pad value from 2 cycles before the final settle edge (synchronizer depth).
- Minimum spacing between grants: one IDLE cycle after every ACK.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `BIDIR_PARK_DRIVE_EN` defined:
  - After a write completes, ACK and IDLE keep `bb_t=0` and `bb_i` equal to the last written bit.
  - Parking ends when a read is granted (SETTLE releases) or on reset.
- Macro undefined: the line is released in ACK and IDLE after every transaction.
- Arbitration, `cur_dir` rules and timing are identical in both builds.

## Test plan
- Defaults after reset; req0 writes 1:
  - Cycles 1-2: `bb_t=1`.
  - Cycles 3-6: `bb_t=0`, `bb_i=1`.
  - Cycle 7: `ack0`.
  - Cycle 8: `busy=0`.
- Immediately after that write, req1 reads with the pad held at 0 externally:
  - Cycles 1-4: `bb_t=1`.
  - Cycle 5: `ack1`, `rdata1=0`.
  - `rdata1` is held until the next read ack to req1.
- req0 and req1 both asserted continuously, all writes, after reset:
  - Grants alternate 0,1,0,1; `owner` tracks the grant.
  - Only the first write (after reset, `cur_dir`=read) incurs TURN.
- `reset_n` low in the third DRIVE cycle:
  - `bb_t=1` within that cycle.
  - No ack is ever issued for that transaction.
  - First request after release is re-arbitrated with req0 priority.
- `TURNAROUND=0`: read then write; DRIVE starts in cycle 1 of the write.
- Write 1 with the `BIDIR_PARK_DRIVE_EN` build:
  - IDLE afterwards holds `bb_t=0`, `bb_i=1` until the next read's first SETTLE cycle.
  - Build without the macro: `bb_t=1` in the ACK cycle.

Source files
------------

// File: rtl/bidir_line_arbiter_if.sv
// Requester-side bus of bidir_line_arbiter: two single-bit request/ack channels.
// Handshake: reqN is a level held until ackN pulses for one cycle. wrN and wdataN are
// sampled in the grant cycle. rdataN is valid from the read ack until the next read ack.
interface bidir_line_arbiter_if;
    logic req0;
    logic req1;
    logic wr0;
    logic wr1;
    logic wdata0;
    logic wdata1;
    logic ack0;
    logic ack1;
    logic rdata0;
    logic rdata1;

    modport master (
        output req0, req1, wr0, wr1, wdata0, wdata1,
        input  ack0, ack1, rdata0, rdata1
    );

    modport slave (
        input  req0, req1, wr0, wr1, wdata0, wdata1,
        output ack0, ack1, rdata0, rdata1
    );
endinterface

// File: rtl/bidir_line_arbiter.sv
// Round-robin sharing of one BB pad between two single-bit requesters, with turnaround,
// hold and settle timing. Optional macro BIDIR_PARK_DRIVE_EN keeps driving after writes.
module bidir_line_arbiter #(
    parameter int TURNAROUND = 2,
    parameter int HOLD       = 4,
    parameter int SETTLE     = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    bidir_line_arbiter_if.slave  bus,
    output logic                 busy,
    output logic                 owner,
    output logic                 bb_i,
    output logic                 bb_t,
    input  logic                 bb_o,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TURN   = 3'd1,
        S_DRIVE  = 3'd2,
        S_SETTLE = 3'd3,
        S_ACK    = 3'd4
    } state_t;

    localparam logic [7:0] TURN_LOAD   = 8'(TURNAROUND - 1);
    localparam logic [7:0] HOLD_LOAD   = 8'(HOLD - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);
    localparam logic       USE_TURN    = (TURNAROUND > 0);

`ifdef BIDIR_PARK_DRIVE_EN
    localparam logic PARK = 1'b1;
`else
    localparam logic PARK = 1'b0;
`endif

    state_t     state;
    logic [7:0] cnt;
    logic       cur_dir;    // direction of last completed transaction, 1 = write
    logic       prio;       // requester that wins a tie
    logic       txn_wdata;
    logic       sync1;
    logic       sync2;
    logic       ack0_q;
    logic       ack1_q;
    logic       rdata0_q;
    logic       rdata1_q;

    logic       grant_valid;
    logic       grant_sel;
    logic       grant_wr;
    logic       grant_wdata;

    always_comb begin
        grant_valid = bus.req0 | bus.req1;
        grant_sel   = 1'b0;
        if (bus.req0 && bus.req1) begin
            grant_sel = prio;
        end else if (bus.req1) begin
            grant_sel = 1'b1;
        end
        grant_wr    = grant_sel ? bus.wr1    : bus.wr0;
        grant_wdata = grant_sel ? bus.wdata1 : bus.wdata0;
    end

    // bb_o is asynchronous to clock
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bb_o;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            cur_dir   <= 1'b0;
            prio      <= 1'b0;
            txn_wdata <= 1'b0;
            owner     <= 1'b0;
            busy      <= 1'b0;
            bb_t      <= 1'b1;
            bb_i      <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rdata0_q  <= 1'b0;
            rdata1_q  <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        owner     <= grant_sel;
                        prio      <= ~grant_sel;
                        txn_wdata <= grant_wdata;
                        busy      <= 1'b1;
                        if (grant_wr) begin
                            if (!cur_dir && USE_TURN) begin
                                state <= S_TURN;
                                cnt   <= TURN_LOAD;
                                bb_t  <= 1'b1;
                                bb_i  <= 1'b0;
                            end else begin
                                state <= S_DRIVE;
                                cnt   <= HOLD_LOAD;
                                bb_t  <= 1'b0;
                                bb_i  <= grant_wdata;
                            end
                        end else begin
                            // a read releases the line at once, parked or not
                            state <= S_SETTLE;
                            cnt   <= SETTLE_LOAD;
                            bb_t  <= 1'b1;
                            bb_i  <= 1'b0;
                        end
                    end
                end
                S_TURN: begin
                    if (cnt == 8'd0) begin
                        state <= S_DRIVE;
                        cnt   <= HOLD_LOAD;
                        bb_t  <= 1'b0;
                        bb_i  <= txn_wdata;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_DRIVE: begin
                    if (cnt == 8'd0) begin
                        state   <= S_ACK;
                        cur_dir <= 1'b1;
                        bb_t    <= ~PARK;
                        bb_i    <= PARK & txn_wdata;
                        if (owner) ack1_q <= 1'b1;
                        else       ack0_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == 8'd0) begin
                        state   <= S_ACK;
                        cur_dir <= 1'b0;
                        if (owner) begin
                            ack1_q   <= 1'b1;
                            rdata1_q <= sync2;
                        end else begin
                            ack0_q   <= 1'b1;
                            rdata0_q <= sync2;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    bb_t  <= 1'b1;
                    bb_i  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_bidir_line_arbiter.sv
// Randomized bench for bidir_line_arbiter: per-cycle line/status expectations and an
// ack scoreboard are derived from the timing rules; honours BIDIR_PARK_DRIVE_EN.
module tb_bidir_line_arbiter;

    localparam int TA  = 2;
    localparam int HLD = 4;
    localparam int STL = 4;
    localparam int W   = 66;   // {who, is_read, ack_cycle[31:0], sample_cycle[31:0]}

`ifdef BIDIR_PARK_DRIVE_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       busy, owner, bb_i, bb_t;
    logic       bb_o = 1'b0;
    logic [2:0] state_dbg;
    int         cyc = 0;

    bidir_line_arbiter_if bus();

    bidir_line_arbiter #(.TURNAROUND(TA), .HOLD(HLD), .SETTLE(STL)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .busy      (busy),
        .owner     (owner),
        .bb_i      (bb_i),
        .bb_t      (bb_t),
        .bb_o      (bb_o),
        .state_dbg (state_dbg)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- reference model state ----------------
    int         checks = 0;
    int         failures = 0;
    logic [W-1:0] exp_q[$];
    bit         e_bt[int];
    bit         e_bi[int];
    bit         e_busy[int];
    bit         e_own[int];
    bit         pad_hist[int];
    bit         cur_dir_m, prio_m, idle_t, idle_i, idle_owner;
    bit         last_rd[2];

    function automatic void model_reset();
        exp_q.delete();
        e_bt.delete();
        e_bi.delete();
        e_busy.delete();
        e_own.delete();
        cur_dir_m  = 1'b0;
        prio_m     = 1'b0;
        idle_t     = 1'b1;
        idle_i     = 1'b0;
        idle_owner = 1'b0;
        last_rd[0] = 1'b0;
        last_rd[1] = 1'b0;
    endfunction

    function automatic void set_cyc(int c, bit t, bit i, bit b, bit o);
        e_bt[c]   = t;
        e_bi[c]   = i;
        e_busy[c] = b;
        e_own[c]  = o;
    endfunction

    // Expected behaviour of one granted transaction starting in IDLE cycle s.
    function automatic int plan(bit who, bit wr, bit wd, int s);
        int turn;
        int ack;
        int sample;
        set_cyc(s, idle_t, idle_i, 1'b0, idle_owner);
        sample = 0;
        if (wr) begin
            turn = (!cur_dir_m && TA > 0) ? TA : 0;
            for (int k = 1; k <= turn; k++) set_cyc(s + k, 1'b1, 1'b0, 1'b1, who);
            for (int k = turn + 1; k <= turn + HLD; k++) set_cyc(s + k, 1'b0, wd, 1'b1, who);
            ack = s + turn + HLD + 1;
            idle_t = !PARK;
            idle_i = PARK & wd;
            cur_dir_m = 1'b1;
        end else begin
            for (int k = 1; k <= STL; k++) set_cyc(s + k, 1'b1, 1'b0, 1'b1, who);
            ack = s + STL + 1;
            sample = s + STL - 2;
            idle_t = 1'b1;
            idle_i = 1'b0;
            cur_dir_m = 1'b0;
        end
        set_cyc(ack, idle_t, idle_i, 1'b1, who);
        set_cyc(ack + 1, idle_t, idle_i, 1'b0, who);
        idle_owner = who;
        prio_m = !who;
        exp_q.push_back({who, !wr, 32'(ack), 32'(sample)});
        return ack;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    task automatic chk(string name, logic got, logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
        end
    endtask

    task automatic check_cycle();
        bit et, ei, eb, eo, ea0, ea1;
        logic [W-1:0] ent;
        if (e_bt.exists(cyc)) begin
            et = e_bt[cyc]; ei = e_bi[cyc]; eb = e_busy[cyc]; eo = e_own[cyc];
        end else begin
            et = idle_t; ei = idle_i; eb = 1'b0; eo = idle_owner;
        end
        ea0 = 1'b0;
        ea1 = 1'b0;
        if (exp_q.size() > 0) begin
            if (exp_q[0][63:32] == 32'(cyc) || bus.ack0 || bus.ack1) begin
                ent = exp_q[0];
                if (ent[63:32] == 32'(cyc)) begin
                    void'(exp_q.pop_front());
                    if (ent[65]) ea1 = 1'b1; else ea0 = 1'b1;
                    if (ent[64]) last_rd[ent[65]] = pad_hist[int'(ent[31:0])];
                end
            end
        end
        chk("ack0", bus.ack0, ea0);
        chk("ack1", bus.ack1, ea1);
        chk("rdata0", bus.rdata0, last_rd[0]);
        chk("rdata1", bus.rdata1, last_rd[1]);
        chk("bb_t", bb_t, et);
        chk("bb_i", bb_i, ei);
        chk("busy", busy, eb);
        chk("owner", owner, eo);
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) check_cycle();
        end
    end

    // External pad: new random level each cycle, remembered for the read model.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            bb_o = 1'($urandom_range(0, 1));
            pad_hist[cyc] = bb_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(bit who, bit r, bit w, bit d);
        if (who) begin
            bus.req1 = r; bus.wr1 = w; bus.wdata1 = d;
        end else begin
            bus.req0 = r; bus.wr0 = w; bus.wdata0 = d;
        end
    endtask

    task automatic wait_until(int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic do_single(bit who, bit wr, bit wd);
        int ack;
        drive_req(who, 1'b1, wr, wd);
        ack = plan(who, wr, wd, cyc);
        wait_until(ack + 1);
        drive_req(who, 1'b0, wr, wd);
    endtask

    // Both requesters held high; each re-requests right after its own ack.
    task automatic do_contention(int n, bit all_wr);
        bit w[2];
        bit d[2];
        bit who;
        int s;
        int ack;
        for (int r = 0; r < 2; r++) begin
            w[r] = all_wr ? 1'b1 : 1'($urandom_range(0, 1));
            d[r] = 1'($urandom_range(0, 1));
            drive_req(r[0], 1'b1, w[r], d[r]);
        end
        s = cyc;
        for (int i = 0; i < n; i++) begin
            who = prio_m;
            ack = plan(who, w[who], d[who], s);
            wait_until(ack + 1);
            if (i == n - 1) begin
                drive_req(1'b0, 1'b0, 1'b0, 1'b0);
                drive_req(1'b1, 1'b0, 1'b0, 1'b0);
            end else begin
                w[who] = all_wr ? 1'b1 : 1'($urandom_range(0, 1));
                d[who] = 1'($urandom_range(0, 1));
                drive_req(who, 1'b1, w[who], d[who]);
            end
            s = ack + 1;
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 1'b0);
        drive_req(1'b1, 1'b0, 1'b0, 1'b0);
        model_reset();
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
    endtask

    task automatic reset_mid_drive();
        int s;
        s = cyc;
        drive_req(1'b0, 1'b1, 1'b1, 1'b1);
        void'(plan(1'b0, 1'b1, 1'b1, s));
        wait_until(s + ((TA > 0) ? TA : 0) + 3);
        chk("drive_before_reset", bb_t, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("rst_bb_t", bb_t, 1'b1);
        chk("rst_bb_i", bb_i, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack0", bus.ack0, 1'b0);
        chk("rst_owner", owner, 1'b0);
        drive_req(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.wr0 = 1'b0; bus.wr1 = 1'b0;
        bus.wdata0 = 1'b0; bus.wdata1 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        next_cycle();

        do_single(1'b0, 1'b1, 1'b1);
        do_single(1'b1, 1'b0, 1'b0);
        next_cycle();
        do_single(1'b1, 1'b0, 1'b0);

        apply_reset();
        do_contention(4, 1'b1);
        next_cycle();

        apply_reset();
        reset_mid_drive();
        do_contention(2, 1'b1);
        next_cycle();

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_contention($urandom_range(2, 5), 1'b0);
            end else begin
                do_single(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
            end
            repeat ($urandom_range(0, 3)) next_cycle();
        end

        repeat (4) next_cycle();
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL pending_acks got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
